seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
Time-multiplexed driver for a NUM_DIGITS common-segment seven-segment display. It holds a frame-stable shadow copy of a packed hex value and scans one digit at a time. Each digit is decoded through the existing seven_seg hex decoder (4-bit in, {a..g} active-high out). A blanking gap between digits suppresses ghosting. It sits between the game/counter logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2); digit 0 = least significant
REFRESH_DIV, 50000, clock cycles each digit is lit per slot (>=1)
BLANK_GAP, 2, clock cycles all digits dark before each digit is lit (>=0)

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
value_in  in  4*NUM_DIGITS  packed hex digits; digit i = value_in[4i+3:4i]
load  in  1  1-cycle strobe; capture value_in for display at next frame boundary
blank_lz  in  1  1 = suppress leading zeros (sampled live)
dp_in  in  NUM_DIGITS  per-digit decimal point; captured with value_in
seg_out  out  7  {a,b,c,d,e,f,g}, active-high, registered
dp_out  out  1  decimal point for the active digit, registered
dig_en  out  NUM_DIGITS  one-hot active-high digit enable, registered; all-zero during gap
frame_done  out  1  1-cycle pulse on the last lit cycle of digit NUM_DIGITS-1

Behaviour:
- Reset (rst=1 at a clk edge): state=GAP, digit index=0, cycle counter=0, shadow value/dp=0, pending flag=0. Outputs seg_out=0, dp_out=0, dig_en=0, frame_done=0.
- FSM states:
  - GAP: dig_en=0, seg_out=0, dp_out=0 for BLANK_GAP cycles, then go to ON. If BLANK_GAP=0, GAP is skipped; ON follows ON directly.
  - ON: dig_en = one-hot of the index, seg_out = decode(shadow digit), dp_out = shadow dp. Lasts REFRESH_DIV cycles, then index advances (NUM_DIGITS-1 wraps to 0) and the FSM enters GAP.
- Slot = BLANK_GAP+REFRESH_DIV cycles; frame = NUM_DIGITS*slot cycles.
- First lit cycle after reset release: digit 0, at cycle BLANK_GAP+1 (outputs registered, 1 cycle after the FSM enters ON).
- Output registering: seg_out, dp_out and dig_en are all registered. They always change together, so no cycle shows a new enable with old segments.
- Load handshake:
  - load=1 latches value_in/dp_in into a pending register and sets the pending flag.
  - A later load before commit overwrites the pending value (last wins).
  - Commit to shadow happens on the edge ending the frame_done cycle. If load=1 in that same cycle, the new value_in commits directly.
  - No tearing: the shadow never changes mid-frame.
- Leading-zero blanking:
  - With blank_lz=1, digit i (i>0) is dark (seg_out=0, dp_out=0, dig_en still asserted) when shadow digits NUM_DIGITS-1..i are all 0.
  - Digit 0 is never blanked.
  - A digit with its dp set is not blanked.
- frame_done: asserted for exactly one cycle per frame, coincident with the last registered lit cycle of digit NUM_DIGITS-1.
- Reset mid-operation: the next cycle returns to the reset state and any pending load is discarded.
- Counter widths: $clog2 of max(REFRESH_DIV,BLANK_GAP,2). Index width is $clog2(NUM_DIGITS).

Decomposition:
- Shared package: FSM state encoding (GAP, ON) and a blank-segment constant 7'b0000000, alongside the existing project defines.
- Sub-module: one instance of the existing seven_seg decoder, fed by the shadow-digit mux. No other sub-modules.

Test Plan:
- Reset, then NUM_DIGITS=4, REFRESH_DIV=4, BLANK_GAP=1, load value 0x12AF:
  - sequence per slot is 1 dark cycle, then 4 cycles of dig_en=0001 seg=1000111 ("F"), then 0010 "A" (1110111), 0100 "2" (1101101), 1000 "1" (0110000);
  - frame_done pulses every 20 cycles.
- Mid-frame tearing check: load 0x0000 while digit 1 is lit in a frame showing 0x12AF:
  - digits 2,3 of the current frame still show 2,1;
  - the next frame shows all "0" (1111110).
- Leading-zero blanking: blank_lz=1, value 0x0030:
  - digits 3,2 show seg=0 with their dig_en asserted;
  - digit 1 shows "3" (1111001), digit 0 shows "0";
  - value 0x0000 shows only digit 0 lit as "0".
- Simultaneous load: loads of 0x1111 then 0x2222 before the boundary, plus load 0x3333 in the frame_done cycle -> next frame shows 3333.
- Reset mid-operation: assert rst while digit 2 is lit -> next cycle dig_en=0, seg_out=0, dp_out=0, shadow=0. After release, digit 0 is lit at cycle BLANK_GAP+1.
- Zero gap and decimal point: BLANK_GAP=0, dp_in=4'b0100 with value 0x0000 and blank_lz=1:
  - dig_en is never all-zero after the first lit cycle;
  - digit 2 shows "0" with dp_out=1, not blanked.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Holds the scan FSM encoding and the dark-segment pattern.
package seven_seg_scanner_pkg;

   typedef enum logic {
      st_gap = 1'b0,
      st_on  = 1'b1
   } state_e;

   localparam logic [6:0] seg_blank = 7'b0000000;

   // Counter must hold both the lit and the gap durations; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned refresh_div,
                                             input int unsigned blank_gap);
      int unsigned m;
      m = 2;
      if (refresh_div > m) m = refresh_div;
      if (blank_gap > m) m = blank_gap;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/seven_seg.sv
// Hex to seven-segment decoder, {a,b,c,d,e,f,g} active-high.
module seven_seg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b0000000;
      unique case (hex)
         4'h0: seg = 7'b1111110;
         4'h1: seg = 7'b0110000;
         4'h2: seg = 7'b1101101;
         4'h3: seg = 7'b1111001;
         4'h4: seg = 7'b0110011;
         4'h5: seg = 7'b1011011;
         4'h6: seg = 7'b1011111;
         4'h7: seg = 7'b1110000;
         4'h8: seg = 7'b1111111;
         4'h9: seg = 7'b1111011;
         4'ha: seg = 7'b1110111;
         4'hb: seg = 7'b0011111;
         4'hc: seg = 7'b1001110;
         4'hd: seg = 7'b0111101;
         4'he: seg = 7'b1001111;
         4'hf: seg = 7'b1000111;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver with frame-stable shadow value,
// inter-digit blanking gap and optional leading-zero suppression.
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLANK_GAP   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   value_in,
   input  logic                      load,
   input  logic                      blank_lz,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   output logic [6:0]                seg_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     dig_en,
   output logic                      frame_done
);

   localparam int unsigned cnt_w = cnt_width(REFRESH_DIV, BLANK_GAP);
   localparam int unsigned idx_w = $clog2(NUM_DIGITS);
   localparam logic [cnt_w-1:0] on_last  = cnt_w'(REFRESH_DIV - 1);
   localparam logic [cnt_w-1:0] gap_last = (BLANK_GAP > 0) ? cnt_w'(BLANK_GAP - 1) : '0;
   localparam logic [idx_w-1:0] idx_last = idx_w'(NUM_DIGITS - 1);
   // With no gap the GAP state is never visited, so scanning starts straight in ON.
   localparam state_e st_reset = (BLANK_GAP > 0) ? st_gap : st_on;

   state_e                    state_q, state_d;
   logic [cnt_w-1:0]          cnt_q, cnt_d;
   logic [idx_w-1:0]          idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
   logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic                      pend_flag_q, pend_flag_d;

   logic [6:0]                seg_d;
   logic                      dp_d;
   logic [NUM_DIGITS-1:0]     dig_en_d;
   logic                      frame_done_d;

   logic [3:0]                cur_hex;
   logic [6:0]                dec_seg;
   logic [NUM_DIGITS-1:0]     lz_blank;
   logic                      all_zero;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      unique case (state_q)
         st_gap: begin
            if (cnt_q == gap_last) begin
               state_d = st_on;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         st_on: begin
            if (cnt_q == on_last) begin
               cnt_d   = '0;
               idx_d   = (idx_q == idx_last) ? '0 : idx_q + 1'b1;
               state_d = (BLANK_GAP > 0) ? st_gap : st_on;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Commit only at the frame boundary; a load in the boundary cycle bypasses pending.
   always_comb begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_flag_d  = pend_flag_q;
      if (frame_done) begin
         pend_flag_d = 1'b0;
         if (load) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
         end else if (pend_flag_q) begin
            shadow_val_d = pend_val_q;
            shadow_dp_d  = pend_dp_q;
         end
      end else if (load) begin
         pend_val_d  = value_in;
         pend_dp_d   = dp_in;
         pend_flag_d = 1'b1;
      end
   end

   // Decode from the next shadow so a zero-gap frame's first digit already sees the commit.
   assign cur_hex = shadow_val_d[{idx_q, 2'b00} +: 4];

   seven_seg u_dec (
      .hex (cur_hex),
      .seg (dec_seg)
   );

   always_comb begin
      lz_blank = '0;
      all_zero = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         all_zero = 1'b1;
         for (int j = i; j < NUM_DIGITS; j++) begin
            if (shadow_val_d[4*j +: 4] != 4'h0) all_zero = 1'b0;
         end
         lz_blank[i] = blank_lz && (i != 0) && !shadow_dp_d[i] && all_zero;
      end
   end

   always_comb begin
      seg_d        = seg_blank;
      dp_d         = 1'b0;
      dig_en_d     = '0;
      frame_done_d = 1'b0;
      if (state_q == st_on) begin
         dig_en_d[idx_q] = 1'b1;
         frame_done_d    = (idx_q == idx_last) && (cnt_q == on_last);
         if (!lz_blank[idx_q]) begin
            seg_d = dec_seg;
            dp_d  = shadow_dp_d[idx_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= st_reset;
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_flag_q  <= 1'b0;
         seg_out      <= seg_blank;
         dp_out       <= 1'b0;
         dig_en       <= '0;
         frame_done   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_flag_q  <= pend_flag_d;
         seg_out      <= seg_d;
         dp_out       <= dp_d;
         dig_en       <= dig_en_d;
         frame_done   <= frame_done_d;
      end
   end

endmodule
